// File: rtl/axi_pkg.sv
// Shared AXI read-side constants, encodings and the read-initiator state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int LEN_BITS   = 8;
  localparam int SIZE_BITS  = 3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } rd_state_t;

endpackage

// File: rtl/axi_addr.sv
// Next beat address for an AXI burst: FIXED holds the address, anything else steps by 2^size.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to load the result.
// Ports: addr (current beat address), size (log2 bytes per beat), burst (encoding),
//        next_addr (address of the following beat, ADDR_WIDTH modular).
module axi_addr
  import axi_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [SIZE_BITS-1:0]  size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] step;

  assign step = ADDR_WIDTH'(1) << size;

  // WRAP and the reserved encoding fall through to linear increment; carry out of the
  // top bit is dropped so the address silently wraps modulo 2^ADDR_WIDTH.
  assign next_addr = (burst == BURST_FIXED) ? addr : (addr + step);

endmodule

// File: rtl/axi_rd_master.sv
// AXI read initiator: takes one burst command, issues AR, streams R beats to the client
// with per-beat address, and reports done/error at burst end.
// Latency: AR one cycle after command accept; R->client combinational; o_done one cycle after last beat.
// Backpressure: o_rready follows i_data_ready in DATA; commands accepted only in IDLE.
// Ports: i_clk/i_rst; client command i_req_*/o_req_ready; AR channel o_ar*/i_arready;
//        R channel i_r*/o_rready; client beat o_data_*/i_data_ready; status o_done/o_err/o_busy.
module axi_rd_master
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [LEN_BITS-1:0]   i_req_len,
  input  logic [SIZE_BITS-1:0]  i_req_size,
  input  logic [1:0]            i_req_burst,
  input  logic [ID_WIDTH-1:0]   i_req_id,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  output logic [LEN_BITS-1:0]   o_arlen,
  output logic [SIZE_BITS-1:0]  o_arsize,
  output logic [1:0]            o_arburst,
  output logic [ID_WIDTH-1:0]   o_arid,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rlast,
  input  logic [ID_WIDTH-1:0]   i_rid,
  output logic                  o_data_valid,
  input  logic                  i_data_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0] o_data_addr,
  output logic                  o_data_last,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_busy
);

  rd_state_t state, next_state;

  logic [ADDR_WIDTH-1:0] araddr;
  logic [LEN_BITS-1:0]   arlen;
  logic [SIZE_BITS-1:0]  arsize;
  logic [1:0]            arburst;
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [ADDR_WIDTH-1:0] next_beat_addr;
  logic [LEN_BITS-1:0]   count;
  logic                  err;
  logic                  done_q;
  logic                  err_q;

  logic last_beat;
  logic xfer;
  logic beat_err;

  // Last beat is decided by our own count against the requested length, never by i_rlast;
  // a slave that disagrees is flagged through beat_err instead.
  assign last_beat = (count == arlen);
  assign xfer      = (state == ST_DATA) && i_rvalid && i_data_ready;
  assign beat_err  = (i_rresp != RESP_OKAY) || (i_rid != arid) || (i_rlast != last_beat);

  axi_addr u_axi_addr (
    .addr      (beat_addr),
    .size      (arsize),
    .burst     (arburst),
    .next_addr (next_beat_addr)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    o_req_ready  = 1'b0;
    o_arvalid    = 1'b0;
    o_rready     = 1'b0;
    o_data_valid = 1'b0;
    o_data_last  = 1'b0;
    o_busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        o_busy      = 1'b0;
        if (i_req_valid) next_state = ST_ADDR;
      end
      ST_ADDR: begin
        o_arvalid = 1'b1;
        if (i_arready) next_state = ST_DATA;
      end
      ST_DATA: begin
        o_rready     = i_data_ready;
        o_data_valid = i_rvalid;
        o_data_last  = last_beat;
        if (xfer && last_beat) next_state = ST_DONE;
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      araddr    <= '0;
      arlen     <= '0;
      arsize    <= '0;
      arburst   <= '0;
      arid      <= '0;
      beat_addr <= '0;
      count     <= '0;
      err       <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_req_valid) begin
            araddr    <= i_req_addr;
            arlen     <= i_req_len;
            arsize    <= i_req_size;
            arburst   <= i_req_burst;
            arid      <= i_req_id;
            beat_addr <= i_req_addr;
            count     <= '0;
            err       <= 1'b0;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            count     <= count + 1'b1;
            beat_addr <= next_beat_addr;
            err       <= err | beat_err;
            // Status is registered here so it lines up with the single DONE cycle.
            if (last_beat) begin
              done_q <= 1'b1;
              err_q  <= err | beat_err;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_araddr    = araddr;
  assign o_arlen     = arlen;
  assign o_arsize    = arsize;
  assign o_arburst   = arburst;
  assign o_arid      = arid;
  assign o_data      = i_rdata;
  assign o_data_addr = beat_addr;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule
